// File: rtl/zed80_pkg.sv
// Shared definitions for the Z80 bus loader: FSM state encoding, default sync
// marker and small state-decode helpers used to build registered outputs.
package zed80_pkg;

    typedef enum logic [3:0] {
        LDR_IDLE,
        LDR_HDR_AH,
        LDR_HDR_AL,
        LDR_HDR_LEN,
        LDR_BUSREQ,
        LDR_DATA,
        LDR_WRITE,
        LDR_CSUM,
        LDR_RELEASE,
        LDR_ABORT
    } ldrState_t;

    localparam logic [7:0] LDR_SYNC_DEFAULT = 8'hA5;

    // Stream side may hand us a byte in these states
    function automatic logic ldrReady(input ldrState_t s);
        return (s == LDR_IDLE) || (s == LDR_HDR_AH) || (s == LDR_HDR_AL) ||
               (s == LDR_HDR_LEN) || (s == LDR_DATA) || (s == LDR_CSUM);
    endfunction

    // Bus request is held from the request phase through the checksum byte
    function automatic logic ldrBusReq(input ldrState_t s);
        return (s == LDR_BUSREQ) || (s == LDR_DATA) || (s == LDR_WRITE) ||
               (s == LDR_CSUM);
    endfunction

    // Loader drives the memory bus only once the CPU has acknowledged
    function automatic logic ldrOwnsBus(input ldrState_t s);
        return (s == LDR_DATA) || (s == LDR_WRITE) || (s == LDR_CSUM);
    endfunction

endpackage

// File: rtl/bus_loader_fsm_timeout.sv
// Loadable 16-bit down-counter with a terminal flag; times the BUSAK wait.
module bus_loader_fsm_timeout (
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic [15:0] loadVal,
    input  logic        dec,
    output logic        term
);

    logic [15:0] count;

    // Load wins over decrement; counting stops at zero
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= 16'd0;
        end else if (load) begin
            count <= loadVal;
        end else if (dec && (count != 16'd0)) begin
            count <= count - 16'd1;
        end
    end

    assign term = (count == 16'd0);

endmodule

// File: rtl/z80_bus_loader.sv
// Framed serial-stream memory loader. Takes the Z80 bus via BUSRQ/BUSAK and
// writes the payload of a SYNC/addr/len/data/csum frame into memory.
module z80_bus_loader
    import zed80_pkg::*;
#(
    parameter int         BUSAK_TIMEOUT = 255,
    parameter logic [7:0] SYNC_BYTE     = LDR_SYNC_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic        busrq_n,
    input  logic        busak_n,
    output logic        bus_oe,
    output logic [15:0] bus_addr,
    output logic [7:0]  bus_dout,
    output logic        bus_mreq_n,
    output logic        bus_wr_n,
    output logic        busy,
    output logic        done,
    output logic        err_csum,
    output logic        err_timeout
);

    // Counter is preloaded with TIMEOUT-1 so the abort edge lands exactly
    // BUSAK_TIMEOUT cycles after entering BUSREQ.
    localparam logic [15:0] TMO_LOAD = 16'(BUSAK_TIMEOUT - 1);

    ldrState_t   state, nxt;
    logic        acc;
    logic [8:0]  remaining;
    logic [7:0]  csum;
    logic        tmoTerm;

    assign acc = in_valid & in_ready;

    bus_loader_fsm_timeout uTmo (
        .clk     (clk),
        .reset   (reset),
        .load    ((state == LDR_HDR_LEN) && acc),
        .loadVal (TMO_LOAD),
        .dec     (state == LDR_BUSREQ),
        .term    (tmoTerm)
    );

    // Next-state decode
    always_comb begin
        nxt = state;
        case (state)
            LDR_IDLE:    if (acc && (in_data == SYNC_BYTE)) nxt = LDR_HDR_AH;
            LDR_HDR_AH:  if (acc) nxt = LDR_HDR_AL;
            LDR_HDR_AL:  if (acc) nxt = LDR_HDR_LEN;
            LDR_HDR_LEN: if (acc) nxt = LDR_BUSREQ;
            LDR_BUSREQ: begin
                if (!busak_n)     nxt = LDR_DATA;
                else if (tmoTerm) nxt = LDR_ABORT;
            end
            LDR_DATA:    if (acc) nxt = LDR_WRITE;
            LDR_WRITE:   nxt = (remaining == 9'd0) ? LDR_CSUM : LDR_DATA;
            LDR_CSUM:    if (acc) nxt = LDR_RELEASE;
            LDR_RELEASE: nxt = LDR_IDLE;
            LDR_ABORT:   nxt = LDR_IDLE;
            default:     nxt = LDR_IDLE;
        endcase
    end

    // State, registered outputs (decoded from next state) and frame datapath
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= LDR_IDLE;
            in_ready    <= 1'b1;
            busrq_n     <= 1'b1;
            bus_oe      <= 1'b0;
            bus_addr    <= 16'h0000;
            bus_dout    <= 8'h00;
            bus_mreq_n  <= 1'b1;
            bus_wr_n    <= 1'b1;
            busy        <= 1'b0;
            done        <= 1'b0;
            err_csum    <= 1'b0;
            err_timeout <= 1'b0;
            remaining   <= 9'd0;
            csum        <= 8'h00;
        end else begin
            state       <= nxt;
            in_ready    <= ldrReady(nxt);
            busrq_n     <= ~ldrBusReq(nxt);
            bus_oe      <= ldrOwnsBus(nxt);
            bus_mreq_n  <= (nxt != LDR_WRITE);
            bus_wr_n    <= (nxt != LDR_WRITE);
            busy        <= (nxt != LDR_IDLE);
            done        <= (state == LDR_CSUM) && acc && (csum == in_data);
            err_csum    <= (state == LDR_CSUM) && acc && (csum != in_data);
            err_timeout <= (nxt == LDR_ABORT);

            case (state)
                LDR_HDR_AH: if (acc) begin
                    bus_addr[15:8] <= in_data;
                    csum           <= in_data;
                end
                LDR_HDR_AL: if (acc) begin
                    bus_addr[7:0] <= in_data;
                    csum          <= csum + in_data;
                end
                LDR_HDR_LEN: if (acc) begin
                    // len of zero encodes a full 256-byte payload
                    remaining <= (in_data == 8'h00) ? 9'd256 : {1'b0, in_data};
                    csum      <= csum + in_data;
                end
                LDR_DATA: if (acc) begin
                    bus_dout  <= in_data;
                    csum      <= csum + in_data;
                    remaining <= remaining - 9'd1;
                end
                // Address advances after the strobe cycle, wrapping at 16 bits
                LDR_WRITE: bus_addr <= bus_addr + 16'd1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_z80_bus_loader.sv
// Directed bench for z80_bus_loader with a small CPU BUSAK responder.
module tb_z80_bus_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic        busrq_n;
    logic        busak_n;
    logic        bus_oe;
    logic [15:0] bus_addr;
    logic [7:0]  bus_dout;
    logic        bus_mreq_n;
    logic        bus_wr_n;
    logic        busy;
    logic        done;
    logic        err_csum;
    logic        err_timeout;

    int checks = 0;
    int errors = 0;

    logic        ackEn = 1'b1;
    logic [1:0]  ackDly = 2'b00;
    logic [15:0] wAddr[$];
    logic [7:0]  wData[$];
    int          strobeBad = 0;

    always #5 clk = ~clk;

    z80_bus_loader #(.BUSAK_TIMEOUT(8), .SYNC_BYTE(8'hA5)) dut (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .busrq_n(busrq_n), .busak_n(busak_n),
        .bus_oe(bus_oe), .bus_addr(bus_addr), .bus_dout(bus_dout),
        .bus_mreq_n(bus_mreq_n), .bus_wr_n(bus_wr_n), .busy(busy),
        .done(done), .err_csum(err_csum), .err_timeout(err_timeout)
    );

    // CPU model: acknowledge two cycles after a request is seen
    assign busak_n = ~ackDly[1];
    always @(negedge clk) ackDly = {ackDly[0], (busrq_n === 1'b0) && ackEn};

    // Write-cycle monitor
    always @(negedge clk) begin
        if (bus_mreq_n === 1'b0 && bus_wr_n === 1'b0) begin
            if (bus_oe === 1'b1) begin
                wAddr.push_back(bus_addr);
                wData.push_back(bus_dout);
            end else begin
                strobeBad++;
            end
        end
    end

    task automatic sendByte(input logic [7:0] b);
        int n = 0;
        in_data  = b;
        in_valid = 1'b1;
        while (in_ready !== 1'b1 && n < 600) begin
            @(negedge clk);
            n++;
        end
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL send_timeout byte=%h in_ready=%b required 1", b, in_ready);
        end
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clearLog();
        wAddr.delete();
        wData.delete();
    endtask

    task automatic test_reset();
        reset = 1'b1; in_valid = 1'b0; in_data = 8'h00;
        repeat (3) @(negedge clk);
        checks++;
        if ({busrq_n, bus_mreq_n, bus_wr_n} !== 3'b111) begin
            errors++; $display("FAIL reset_high_outs got %b required 111", {busrq_n, bus_mreq_n, bus_wr_n});
        end
        checks++;
        if ({bus_oe, busy, done, err_csum, err_timeout} !== 5'b00000) begin
            errors++; $display("FAIL reset_low_outs got %b required 00000", {bus_oe, busy, done, err_csum, err_timeout});
        end
        checks++;
        if (bus_addr !== 16'h0000 || bus_dout !== 8'h00) begin
            errors++; $display("FAIL reset_bus got %h/%h required 0000/00", bus_addr, bus_dout);
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL reset_ready got %b required 1", in_ready);
        end
        reset = 1'b0;
        idle(2);
    endtask

    task automatic test_frame_a();
        logic [15:0] ea[3] = '{16'h2000, 16'h2001, 16'h2002};
        logic [7:0]  ed[3] = '{8'h11, 8'h22, 8'h33};
        clearLog();
        sendByte(8'hA5); sendByte(8'h20); sendByte(8'h00); sendByte(8'h03);
        checks++;
        if (busrq_n !== 1'b0 || bus_oe !== 1'b0 || busy !== 1'b1) begin
            errors++; $display("FAIL busrq_fall rq=%b oe=%b busy=%b required 0 0 1", busrq_n, bus_oe, busy);
        end
        sendByte(8'h11);
        checks++;
        if (bus_wr_n !== 1'b0 || bus_addr !== 16'h2000 || bus_dout !== 8'h11 || bus_oe !== 1'b1) begin
            errors++; $display("FAIL first_write wr=%b addr=%h dout=%h oe=%b required 0 2000 11 1", bus_wr_n, bus_addr, bus_dout, bus_oe);
        end
        sendByte(8'h22); sendByte(8'h33); sendByte(8'h89);
        checks++;
        if (done !== 1'b1 || err_csum !== 1'b0 || busrq_n !== 1'b1 || bus_oe !== 1'b0) begin
            errors++; $display("FAIL done_pulse done=%b ec=%b rq=%b oe=%b required 1 0 1 0", done, err_csum, busrq_n, bus_oe);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL done_width done=%b busy=%b required 0 0", done, busy);
        end
        checks++;
        if (wAddr.size() != 3) begin
            errors++; $display("FAIL a_write_count got %0d required 3", wAddr.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (wAddr[i] !== ea[i] || wData[i] !== ed[i]) begin
                    errors++; $display("FAIL a_write%0d got %h=%h required %h=%h", i, wAddr[i], wData[i], ea[i], ed[i]);
                end
            end
        end
        idle(4);
    endtask

    task automatic test_csum_bad();
        clearLog();
        sendByte(8'hA5); sendByte(8'h20); sendByte(8'h00); sendByte(8'h03);
        sendByte(8'h11); sendByte(8'h22); sendByte(8'h33); sendByte(8'h00);
        checks++;
        if (err_csum !== 1'b1 || done !== 1'b0 || busrq_n !== 1'b1) begin
            errors++; $display("FAIL csum_err ec=%b done=%b rq=%b required 1 0 1", err_csum, done, busrq_n);
        end
        checks++;
        if (wAddr.size() != 3 || wData.size() != 3) begin
            errors++; $display("FAIL csum_writes got %0d required 3", wAddr.size());
        end else if (wAddr[2] !== 16'h2002 || wData[2] !== 8'h33) begin
            errors++; $display("FAIL csum_writes last %h=%h required 2002=33", wAddr[2], wData[2]);
        end
        idle(4);
    endtask

    task automatic test_wrap();
        clearLog();
        sendByte(8'hA5); sendByte(8'hFF); sendByte(8'hFF); sendByte(8'h02);
        sendByte(8'hAA); sendByte(8'hBB); sendByte(8'h65);
        checks++;
        if (done !== 1'b1 || err_csum !== 1'b0) begin
            errors++; $display("FAIL wrap_done done=%b ec=%b required 1 0", done, err_csum);
        end
        checks++;
        if (wAddr.size() != 2) begin
            errors++; $display("FAIL wrap_count got %0d required 2", wAddr.size());
        end else if (wAddr[0] !== 16'hFFFF || wData[0] !== 8'hAA ||
                     wAddr[1] !== 16'h0000 || wData[1] !== 8'hBB) begin
            errors++; $display("FAIL wrap_writes got %h=%h %h=%h required FFFF=AA 0000=BB", wAddr[0], wData[0], wAddr[1], wData[1]);
        end
        idle(4);
    endtask

    task automatic test_timeout();
        int early = 0;
        clearLog();
        strobeBad = 0;
        ackEn = 1'b0;
        sendByte(8'hA5); sendByte(8'h12); sendByte(8'h34); sendByte(8'h01);
        for (int k = 1; k < 8; k++) begin
            @(negedge clk);
            if (err_timeout !== 1'b0 || busrq_n !== 1'b0) early++;
        end
        checks++;
        if (early != 0) begin
            errors++; $display("FAIL tmo_early bad_cycles=%0d required 0", early);
        end
        @(negedge clk);
        checks++;
        if (err_timeout !== 1'b1 || busrq_n !== 1'b1 || bus_oe !== 1'b0) begin
            errors++; $display("FAIL tmo_pulse et=%b rq=%b oe=%b required 1 1 0", err_timeout, busrq_n, bus_oe);
        end
        @(negedge clk);
        checks++;
        if (err_timeout !== 1'b0 || busy !== 1'b0 || wAddr.size() != 0 || strobeBad != 0) begin
            errors++; $display("FAIL tmo_after et=%b busy=%b writes=%0d stray=%0d required 0 0 0 0", err_timeout, busy, wAddr.size(), strobeBad);
        end
        ackEn = 1'b1;
        idle(4);
    endtask

    task automatic test_garbage();
        clearLog();
        sendByte(8'h00); sendByte(8'hFF); sendByte(8'h5A);
        checks++;
        if (busy !== 1'b0 || busrq_n !== 1'b1) begin
            errors++; $display("FAIL garbage_idle busy=%b rq=%b required 0 1", busy, busrq_n);
        end
        sendByte(8'hA5); sendByte(8'h20); sendByte(8'h00); sendByte(8'h03);
        sendByte(8'h11); sendByte(8'h22); sendByte(8'h33); sendByte(8'h89);
        checks++;
        if (done !== 1'b1 || wAddr.size() != 3) begin
            errors++; $display("FAIL garbage_frame done=%b writes=%0d required 1 3", done, wAddr.size());
        end
        idle(4);
    endtask

    task automatic test_reset_mid();
        clearLog();
        strobeBad = 0;
        sendByte(8'hA5); sendByte(8'h20); sendByte(8'h00); sendByte(8'h03);
        sendByte(8'h11);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (busrq_n !== 1'b1 || bus_oe !== 1'b0 || bus_mreq_n !== 1'b1 ||
            bus_wr_n !== 1'b1 || busy !== 1'b0 || in_ready !== 1'b1) begin
            errors++; $display("FAIL mid_reset rq=%b oe=%b mreq=%b wr=%b busy=%b rdy=%b required 1 0 1 1 0 1",
                               busrq_n, bus_oe, bus_mreq_n, bus_wr_n, busy, in_ready);
        end
        reset = 1'b0;
        idle(4);
        checks++;
        if (wAddr.size() != 1 || strobeBad != 0) begin
            errors++; $display("FAIL mid_writes got %0d stray=%0d required 1 0", wAddr.size(), strobeBad);
        end
        clearLog();
        sendByte(8'hA5); sendByte(8'h20); sendByte(8'h00); sendByte(8'h03);
        sendByte(8'h11); sendByte(8'h22); sendByte(8'h33); sendByte(8'h89);
        checks++;
        if (done !== 1'b1 || wAddr.size() != 3) begin
            errors++; $display("FAIL mid_recover done=%b writes=%0d required 1 3", done, wAddr.size());
        end
        idle(4);
    endtask

    initial begin
        test_reset();
        test_frame_a();
        test_csum_bad();
        test_wrap();
        test_timeout();
        test_garbage();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
